// File: rtl/mem_lsu.sv
// Load/store unit in front of a single-cycle data memory: one request at a time,
// alignment/range checking, one-cycle memory access, load extension and debug counters.
module mem_lsu #(
  parameter int DM_WORDS = 512,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             dm_MemR,
  output logic             dm_MemWr,
  output logic [1:0]       dm_MemWrBits,
  output logic [1:0]       dm_MemRBits,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_data,
  input  logic [31:0]      dm_ReadData,
  output logic [CNT_W-1:0] cnt_ld,
  output logic [CNT_W-1:0] cnt_st,
  output logic [CNT_W-1:0] cnt_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_ld_q, cnt_ld_d;
  logic [CNT_W-1:0]  cnt_st_q, cnt_st_d;
  logic [CNT_W-1:0]  cnt_err_q, cnt_err_d;

  logic              req_err;
  logic              in_access;
  logic [31:0]       load_ext;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign req_ready = (state_q == IDLE) & rstn;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign cnt_ld    = cnt_ld_q;
  assign cnt_st    = cnt_st_q;
  assign cnt_err   = cnt_err_q;

  // NOTE: memory strobes are decoded from the state register, not registered,
  // so an asynchronous reset during ACCESS removes the write before the next edge.
  assign in_access    = (state_q == ACCESS);
  assign dm_MemR      = in_access & ~we_q;
  assign dm_MemWr     = in_access & we_q;
  assign dm_MemRBits  = (in_access & ~we_q) ? size_q : 2'b00;
  assign dm_MemWrBits = (in_access & we_q) ? size_q : 2'b00;
  assign dm_addr      = in_access ? addr_q : 32'h0;
  assign dm_data      = in_access ? wdata_q : 32'h0;

  always_comb begin
    req_err = (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b00) & (|req_addr[1:0]))
            | ({2'b00, req_addr[31:2]} >= 32'(DM_WORDS));
  end

  // Memory returns zero-extended data; only signed half/byte loads need work.
  always_comb begin
    load_ext = dm_ReadData;
    if (sgn_q) begin
      case (size_q)
        2'b01:   load_ext = {{16{dm_ReadData[15]}}, dm_ReadData[15:0]};
        2'b10:   load_ext = {{24{dm_ReadData[7]}}, dm_ReadData[7:0]};
        default: load_ext = dm_ReadData;
      endcase
    end
  end

  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_ld_d  = cnt_ld_q;
    cnt_st_d  = cnt_st_q;
    cnt_err_d = cnt_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_err;
          rdata_d = 32'h0;
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = we_q ? 32'h0 : load_ext;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (err_q)     cnt_err_d = sat_inc(cnt_err_q);
          else if (we_q) cnt_st_d  = sat_inc(cnt_st_q);
          else           cnt_ld_d  = sat_inc(cnt_ld_q);
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      sgn_q     <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      cnt_ld_q  <= '0;
      cnt_st_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_ld_q  <= cnt_ld_d;
      cnt_st_q  <= cnt_st_d;
      cnt_err_q <= cnt_err_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: a byte-array data memory driven by the dm_* port,
// plus an independent reference model of accesses, extension and saturating counters.
module tb_mem_lsu;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid, req_ready, req_we, req_signed;
  logic [1:0]       req_size;
  logic [31:0]      req_addr, req_wdata;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [31:0]      rsp_rdata;
  logic             dm_MemR, dm_MemWr;
  logic [1:0]       dm_MemWrBits, dm_MemRBits;
  logic [31:0]      dm_addr, dm_data, dm_ReadData;
  logic [CNT_W-1:0] cnt_ld, cnt_st, cnt_err;

  int total = 0;
  int bad   = 0;

  mem_lsu #(.DM_WORDS(512), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .dm_MemR(dm_MemR), .dm_MemWr(dm_MemWr), .dm_MemWrBits(dm_MemWrBits),
    .dm_MemRBits(dm_MemRBits), .dm_addr(dm_addr), .dm_data(dm_data),
    .dm_ReadData(dm_ReadData),
    .cnt_ld(cnt_ld), .cnt_st(cnt_st), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT: little-endian bytes, combinational zero-extended read.
  logic [7:0]  tb_mem [2048] = '{default: 8'h00};
  logic [10:0] mem_a;
  assign mem_a = dm_addr[10:0];

  always_comb begin
    dm_ReadData = 32'h0;
    case (dm_MemRBits)
      2'b00:   dm_ReadData = {tb_mem[mem_a + 11'd3], tb_mem[mem_a + 11'd2],
                              tb_mem[mem_a + 11'd1], tb_mem[mem_a]};
      2'b01:   dm_ReadData = {16'h0, tb_mem[mem_a + 11'd1], tb_mem[mem_a]};
      default: dm_ReadData = {24'h0, tb_mem[mem_a]};
    endcase
  end

  always @(posedge clk) begin
    if (dm_MemWr) begin
      tb_mem[mem_a] <= dm_data[7:0];
      if (dm_MemWrBits != 2'b10) tb_mem[mem_a + 11'd1] <= dm_data[15:8];
      if (dm_MemWrBits == 2'b00) begin
        tb_mem[mem_a + 11'd2] <= dm_data[23:16];
        tb_mem[mem_a + 11'd3] <= dm_data[31:24];
      end
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [2048];
  int exp_ld = 0, exp_st = 0, exp_err = 0;

  task automatic model_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err);
    int nbytes;
    logic [31:0] v;
    nbytes = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
    err    = (size == 2'd3) || (addr % nbytes != 0) || (addr / 4 >= 512);
    rdata  = 32'h0;
    if (err) begin
      exp_err = (exp_err == CMAX) ? exp_err : exp_err + 1;
    end else if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      exp_st = (exp_st == CMAX) ? exp_st : exp_st + 1;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
      if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
      rdata  = v;
      exp_ld = (exp_ld == CMAX) ? exp_ld : exp_ld + 1;
    end
  endtask

  // Issues one request with rsp_ready high and records what the DUT did.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int wr_cyc, output int rd_cyc, output int lat);
    bit got;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = ~we;
    wr_cyc = 0; rd_cyc = 0; lat = 99; rdata = 32'hx; err = 1'bx; got = 1'b0;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      if (dm_MemWr) wr_cyc++;
      if (dm_MemR)  rd_cyc++;
      if (rsp_valid) begin rdata = rsp_rdata; err = rsp_err; lat = i; got = 1'b1; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    #12;
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_rsp got ready=%b valid=%b rdata=%h err=%b exp 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    total++;
    if ({dm_MemR, dm_MemWr, dm_MemWrBits, dm_MemRBits} !== 6'h0 || dm_addr !== 32'h0 || dm_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_dm got r=%b w=%b addr=%h data=%h exp all 0", dm_MemR, dm_MemWr, dm_addr, dm_data);
    end
    total++;
    if (cnt_ld !== '0 || cnt_st !== '0 || cnt_err !== '0) begin
      bad++;
      $display("FAIL reset_cnt got %0d %0d %0d exp 0 0 0", cnt_ld, cnt_st, cnt_err);
    end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_word;
    logic [31:0] r, er; logic e, ee; int w, rd, l;
    do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, r, e, w, rd, l);
    model_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, er, ee);
    total++;
    if (w !== 1 || rd !== 0 || l !== 2 || e !== 1'b0 || r !== 32'h0) begin
      bad++;
      $display("FAIL sw_word got wr=%0d rd=%0d lat=%0d err=%b rdata=%h exp 1 0 2 0 0", w, rd, l, e, r);
    end
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, r, e, w, rd, l);
    model_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, er, ee);
    total++;
    if (r !== 32'hDEADBEEF || e !== 1'b0 || rd !== 1 || w !== 0 || l !== 2) begin
      bad++;
      $display("FAIL lw_word got rdata=%h err=%b rd=%0d wr=%0d lat=%0d exp deadbeef 0 1 0 2", r, e, rd, w, l);
    end
    total++;
    if (cnt_st !== CNT_W'(1) || cnt_ld !== CNT_W'(1)) begin
      bad++;
      $display("FAIL word_cnt got st=%0d ld=%0d exp 1 1", cnt_st, cnt_ld);
    end
  endtask

  typedef struct {
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_t;

  task automatic test_byte_half;
    logic [31:0] r, er; logic e, ee; int w, rd, l;
    ld_t tab [4];
    tab = '{'{2'b10, 1'b1, 32'h21, 32'hFFFFFF80}, '{2'b10, 1'b0, 32'h21, 32'h00000080},
            '{2'b01, 1'b1, 32'h32, 32'hFFFF8001}, '{2'b01, 1'b0, 32'h32, 32'h00008001}};
    do_req(1'b1, 2'b10, 1'b0, 32'h21, 32'h12345680, r, e, w, rd, l);
    model_req(1'b1, 2'b10, 1'b0, 32'h21, 32'h12345680, er, ee);
    do_req(1'b1, 2'b01, 1'b0, 32'h32, 32'hABCD8001, r, e, w, rd, l);
    model_req(1'b1, 2'b01, 1'b0, 32'h32, 32'hABCD8001, er, ee);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, tab[i].size, tab[i].sgn, tab[i].addr, 32'h0, r, e, w, rd, l);
      model_req(1'b0, tab[i].size, tab[i].sgn, tab[i].addr, 32'h0, er, ee);
      total++;
      if (r !== tab[i].exp || e !== 1'b0) begin
        bad++;
        $display("FAIL subword_load[%0d] got rdata=%h err=%b exp rdata=%h err=0", i, r, e, tab[i].exp);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] r, er; logic e, ee; int w, rd, l;
    logic        we_t   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  size_t [4] = '{2'b00, 2'b01, 2'b11, 2'b00};
    logic [31:0] addr_t [4] = '{32'h13, 32'h05, 32'h20, 32'h800};
    for (int i = 0; i < 4; i++) begin
      do_req(we_t[i], size_t[i], 1'b0, addr_t[i], 32'hFFFFFFFF, r, e, w, rd, l);
      model_req(we_t[i], size_t[i], 1'b0, addr_t[i], 32'hFFFFFFFF, er, ee);
      total++;
      if (e !== 1'b1 || r !== 32'h0 || w !== 0 || rd !== 0 || l !== 1) begin
        bad++;
        $display("FAIL err_req[%0d] got err=%b rdata=%h wr=%0d rd=%0d lat=%0d exp 1 0 0 0 1", i, e, r, w, rd, l);
      end
    end
    total++;
    if (cnt_err !== CNT_W'(4)) begin bad++; $display("FAIL err_cnt got=%0d exp=4", cnt_err); end
  endtask

  task automatic test_stall;
    logic [31:0] er, sr; logic ee, se;
    model_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, er, ee);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h12345678;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0 || dm_MemR !== 1'b1) begin
      bad++;
      $display("FAIL stall_access got ready=%b memr=%b exp 0 1", req_ready, dm_MemR);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== 1'b0 || req_ready !== 1'b0 || dm_MemWr !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d] got valid=%b rdata=%h err=%b ready=%b memwr=%b exp 1 %h 0 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, dm_MemWr, er);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || cnt_ld !== CNT_W'(exp_ld) || cnt_st !== CNT_W'(exp_st)) begin
      bad++;
      $display("FAIL stall_release got valid=%b ready=%b ld=%0d st=%0d exp 0 1 %0d %0d",
               rsp_valid, req_ready, cnt_ld, cnt_st, exp_ld, exp_st);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_req(1'b1, 2'b00, 1'b0, 32'h44, 32'h12345678, sr, se);
    @(negedge clk);
    total++;
    if (dm_MemWr !== 1'b1 || dm_addr !== 32'h44 || dm_data !== 32'h12345678) begin
      bad++;
      $display("FAIL stall_late_store got wr=%b addr=%h data=%h exp 1 44 12345678", dm_MemWr, dm_addr, dm_data);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL stall_late_rsp got valid=%b err=%b exp 1 0", rsp_valid, rsp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] r, er; logic e, ee; int w, rd, l;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (dm_MemWr !== 1'b1) begin bad++; $display("FAIL abort_pre got memwr=%b exp=1", dm_MemWr); end
    #2 rstn = 1'b0;
    #1;
    total++;
    if (dm_MemWr !== 1'b0 || dm_MemR !== 1'b0 || dm_addr !== 32'h0 || dm_data !== 32'h0 ||
        rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs got wr=%b addr=%h valid=%b ready=%b exp 0 0 0 0",
               dm_MemWr, dm_addr, rsp_valid, req_ready);
    end
    total++;
    if (cnt_ld !== '0 || cnt_st !== '0 || cnt_err !== '0) begin
      bad++;
      $display("FAIL abort_cnt got %0d %0d %0d exp 0 0 0", cnt_ld, cnt_st, cnt_err);
    end
    exp_ld = 0; exp_st = 0; exp_err = 0;
    @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    do_req(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, r, e, w, rd, l);
    model_req(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, er, ee);
    total++;
    if (r !== 32'h0 || e !== 1'b0 || l !== 2) begin
      bad++;
      $display("FAIL abort_readback got rdata=%h err=%b lat=%0d exp 0 0 2", r, e, l);
    end
  endtask

  task automatic test_random;
    logic [31:0] r, er, addr, wdata; logic e, ee, we, sgn; logic [1:0] size; int w, rd, l, nb;
    for (int n = 0; n < 60; n++) begin
      we    = 1'($urandom_range(0, 1));
      sgn   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, 2));
      nb    = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
      wdata = $urandom;
      addr  = 32'h200 + $urandom_range(0, 63);
      if ($urandom_range(0, 7) != 0) addr = addr - (addr % nb);
      if ($urandom_range(0, 15) == 0) addr = 32'h800 + $urandom_range(0, 16'hFFFF);
      do_req(we, size, sgn, addr, wdata, r, e, w, rd, l);
      model_req(we, size, sgn, addr, wdata, er, ee);
      total++;
      if (r !== er || e !== ee || w !== ((!ee && we) ? 1 : 0) || rd !== ((!ee && !we) ? 1 : 0) || l !== (ee ? 1 : 2)) begin
        bad++;
        $display("FAIL rand[%0d] we=%b sz=%0d a=%h got rdata=%h err=%b wr=%0d rd=%0d lat=%0d exp rdata=%h err=%b",
                 n, we, size, addr, r, e, w, rd, l, er, ee);
      end
    end
    total++;
    if (cnt_ld !== CNT_W'(exp_ld) || cnt_st !== CNT_W'(exp_st) || cnt_err !== CNT_W'(exp_err)) begin
      bad++;
      $display("FAIL rand_cnt got ld=%0d st=%0d err=%0d exp %0d %0d %0d",
               cnt_ld, cnt_st, cnt_err, exp_ld, exp_st, exp_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    test_reset;
    test_word;
    test_byte_half;
    test_errors;
    test_stall;
    test_reset_mid_access;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
